rr_mux_scheduler: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit output channel among NUM_INPUTS requesters.
- Each requester presents valid/data; the block grants one per cycle, steers its data through an N:1 select, and registers it into a single output stage with a valid/ready handshake.
- Sits between multiple producers and one consumer, and sequences the mux select that a plain multiplexer leaves to its user.

---
 rtl/rr_mux_pkg.sv | 11 +
 rtl/rr_mux_scheduler_pick.sv | 30 +++
 rtl/rr_mux_scheduler.sv | 60 ++++++
 tb/tb_rr_mux_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and pointer helper for the round-robin mux scheduler
package rr_mux_pkg;

    typedef enum logic {EMPTY, FULL} out_state_t;

    // Next index after last, wrapping by comparison so non-power-of-two counts stay in range
    function automatic int unsigned rr_next(input int unsigned last, input int unsigned n);
        return (last >= n - 1) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/rr_mux_scheduler_pick.sv
// rr_pick: first valid requester at or after last_grant+1, with wrap-around
module rr_pick import rr_mux_pkg::*; #(
    parameter  int NUM_INPUTS = 8,
    localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_valid,
    input  logic [SEL_W-1:0]      last_grant,
    output logic [SEL_W-1:0]      pick,
    output logic                  any_req
);

    logic        found;
    int unsigned idx;

    // Walk every index once starting after the previous winner; the first valid one wins
    always_comb begin
        pick    = '0;
        any_req = |req_valid;
        found   = 1'b0;
        idx     = rr_next(32'(last_grant), NUM_INPUTS);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!found && req_valid[idx]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end
            idx = rr_next(idx, NUM_INPUTS);
        end
    end

endmodule

// File: rtl/rr_mux_scheduler.sv
// rr_mux_scheduler: round-robin N:1 scheduler feeding one registered valid/ready output
module rr_mux_scheduler import rr_mux_pkg::*; #(
    parameter  int NUM_INPUTS = 8,
    parameter  int WIDTH      = 8,
    localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req_valid,
    input  logic [WIDTH-1:0]      req_data [NUM_INPUTS],
    output logic [NUM_INPUTS-1:0] req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    out_state_t       state, next_state;
    logic [SEL_W-1:0] pick, last_grant;
    logic             any_req, load, take;

    rr_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .pick      (pick),
        .any_req   (any_req)
    );

    assign out_valid = (state == FULL);
    assign load      = (state == EMPTY) | (out_ready & out_valid);
    assign take      = rst_n & load & any_req;
    assign req_ready = take ? (NUM_INPUTS'(1) << pick) : '0;
    assign busy      = out_valid | (|req_valid);

    // Output-register occupancy; reset empties it immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    end

    // Refill when the slot is free or draining this cycle, otherwise hold
    always_comb begin
        next_state = load ? (any_req ? FULL : EMPTY) : state;
    end

    // Capture the granted word and advance the round-robin pointer only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SEL_W'(NUM_INPUTS - 1);
        end else if (take) begin
            out_data   <= req_data[pick];
            out_src    <= pick;
            last_grant <= pick;
        end
    end

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// tb_rr_mux_scheduler: scoreboard bench for the round-robin mux scheduler
module tb_rr_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rv = '0;
    logic [7:0] rd [8];
    logic [7:0] rdy;
    logic       ov, ordy = 1'b0, busy;
    logic [7:0] od;
    logic [2:0] osrc;

    logic [4:0] rv5 = '0;
    logic [7:0] rd5 [5];
    logic [4:0] rdy5;
    logic       ov5, busy5;
    logic       ordy5 = 1'b0;
    logic [7:0] od5;
    logic [2:0] osrc5;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int src; int data; } exp_t;
    exp_t q[$];
    logic m_full = 1'b0;
    int   m_last = 7;

    always #5 clk = ~clk;

    rr_mux_scheduler #(.NUM_INPUTS(8), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd), .req_ready(rdy),
        .out_valid(ov), .out_data(od), .out_src(osrc), .out_ready(ordy), .busy(busy)
    );

    rr_mux_scheduler #(.NUM_INPUTS(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv5), .req_data(rd5), .req_ready(rdy5),
        .out_valid(ov5), .out_data(od5), .out_src(osrc5), .out_ready(ordy5), .busy(busy5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [7:0] v, input int last);
        for (int k = 1; k <= 8; k++)
            if (v[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    // Reference model: predict grants, push captured words, compare the output slot against the queue head
    always @(negedge clk) begin
        logic       m_load;
        int         p;
        logic [7:0] er;
        if (!rst_n) begin
            m_full = 1'b0;
            m_last = 7;
            q.delete();
        end else begin
            m_load = !m_full || ordy;
            p      = model_pick(rv, m_last);
            er     = (m_load && p >= 0) ? 8'(1 << p) : 8'h00;
            check("req_ready", 32'(rdy), 32'(er));
            check("out_valid", 32'(ov), 32'(m_full));
            check("busy", 32'(busy), 32'(m_full | (|rv)));
            if (m_full) begin
                if (q.size() == 0) check("sb_empty", 0, 1);
                else begin
                    check("sb_src", 32'(osrc), 32'(q[0].src));
                    check("sb_data", 32'(od), 32'(q[0].data));
                    if (ordy) void'(q.pop_front());
                end
            end
            if (m_load) begin
                if (p >= 0) begin
                    q.push_back('{src: p, data: int'(rd[p])});
                    m_last = p;
                    m_full = 1'b1;
                end else m_full = 1'b0;
            end
        end
    end

    initial begin
        for (int j = 0; j < 8; j++) rd[j] = 8'(j + 1);
        for (int j = 0; j < 5; j++) rd5[j] = 8'(j + 1);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_valid", 32'(ov), 0);
            check("idle_ready", 32'(rdy), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_src", 32'(osrc), 0);
        end
        rv = 8'hFF;
        ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("rr_src", 32'(osrc), 32'(i % 8));
            check("rr_data", 32'(od), 32'(i % 8 + 1));
        end
        rv = 8'h24;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("alt_src", 32'(osrc), (i % 2 == 0) ? 2 : 5);
        end
        rv = 8'h08;
        tick(1);
        check("pre_stall_src", 32'(osrc), 3);
        rv = 8'hFF;
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("stall_data", 32'(od), 4);
            check("stall_src", 32'(osrc), 3);
            check("stall_ready", 32'(rdy), 0);
        end
        ordy = 1'b1;
        #1;
        check("release_ready", 32'(rdy), 32'h10);
        tick(1);
        check("release_src", 32'(osrc), 4);
        rv = 8'h40;
        tick(1);
        check("pre_rst_src", 32'(osrc), 6);
        rv = 8'h00;
        ordy = 1'b0;
        check("pre_rst_valid", 32'(ov), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ov), 0);
        check("async_rst_ready", 32'(rdy), 0);
        check("async_rst_src", 32'(osrc), 0);
        tick(1);
        rst_n = 1'b1;
        rv = 8'hFF;
        ordy = 1'b1;
        #1;
        check("post_rst_ready", 32'(rdy), 32'h01);
        tick(1);
        check("post_rst_src", 32'(osrc), 0);
        rv = 8'h00;
        rv5 = 5'h1F;
        ordy5 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("n5_valid", 32'(ov5), 1);
            check("n5_src", 32'(osrc5), 32'(i % 5));
            check("n5_data", 32'(od5), 32'(i % 5 + 1));
        end
        rv5 = '0;
        tick(3);
        check("sb_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
